// File: rtl/fetch_unpacker.sv
// Fetch unpacker: splits 2-slot fetch packets from a showahead FIFO into single
// instructions on a registered valid/ready port. Optional perf counters: FETCH_UNPACK_PERF_EN.
module fetch_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst0,
  input  logic [DATA_WIDTH-1:0] in_inst1,
  input  logic [1:0]            in_mask,
  output logic                  in_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_slot,
  output logic [31:0]           perf_inst_cnt,
  output logic [31:0]           perf_bubble_cnt
);

  logic ptr;
  logic load, has_slot, sel, last, emit;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^in_pc[2:0];

  // Slot 0 is only eligible while the pointer still sits on it; slot 1 is the fallback.
  always_comb begin
    load     = ~out_valid | out_ready;
    has_slot = (~ptr & in_mask[0]) | in_mask[1];
    sel      = ~(~ptr & in_mask[0]);
    last     = ~(~ptr & in_mask[0] & in_mask[1]);
    emit     = in_valid & load & ~flush & has_slot;
    in_pop   = rst_n & in_valid & load & last & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_slot  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= emit;
      if (emit) begin
        out_inst <= sel ? in_inst1 : in_inst0;
        out_pc   <= {in_pc[PC_WIDTH-1:3], sel, 2'b00};
        out_slot <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (flush)  ptr <= 1'b0;
    else if (in_pop) ptr <= 1'b0;
    else if (emit)   ptr <= ~sel;
  end

  // The head packet must not change shape once its slot 0 has been consumed.
  mask_stable_a: assert property (@(posedge clk) disable iff (!rst_n || flush)
    (ptr && in_valid && $past(in_valid)) |-> $stable(in_mask));

`ifdef FETCH_UNPACK_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_cnt   <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (out_valid & out_ready)  perf_inst_cnt   <= perf_inst_cnt + 32'd1;
      if (out_ready & ~out_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_inst_cnt   = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unpacker.sv
// Bench for fetch_unpacker: directed scenarios plus a randomized stream checked
// against a packet-expansion model with a FIFO model driving the input side.
module tb_fetch_unpacker;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        in_valid = 0, in_pop, out_valid, out_ready = 0, out_slot;
  logic [31:0] in_pc = 0, in_inst0 = 0, in_inst1 = 0, out_pc, out_inst;
  logic [1:0]  in_mask = 0;
  logic [31:0] perf_inst_cnt, perf_bubble_cnt;

  fetch_unpacker #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_mask(in_mask), .in_pop(in_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_slot(out_slot), .perf_inst_cnt(perf_inst_cnt), .perf_bubble_cnt(perf_bubble_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc, i0, i1; logic [1:0] m; } pkt_t;
  typedef struct { logic [31:0] pc, inst; logic slot; } ins_t;
  pkt_t pq[$];
  int checks = 0, failures = 0;
  logic s_vld, s_pop, s_slot, s_acc;
  logic [31:0] s_pc, s_inst;

  function automatic pkt_t mk(logic [31:0] pc, logic [1:0] m, logic [31:0] i0, logic [31:0] i1);
    pkt_t p; p.pc = pc; p.m = m; p.i0 = i0; p.i1 = i1; return p;
  endfunction

  task automatic drive_head();
    in_valid = pq.size() > 0;
    if (pq.size() > 0) begin
      in_pc = pq[0].pc; in_mask = pq[0].m; in_inst0 = pq[0].i0; in_inst1 = pq[0].i1;
    end else begin
      in_pc = $urandom; in_mask = 2'b00; in_inst0 = $urandom; in_inst1 = $urandom;
    end
  endtask

  // Sample pre-edge values on the falling edge, then retire a popped head like the FIFO would.
  task automatic cyc();
    @(negedge clk);
    s_vld = out_valid; s_pc = out_pc; s_inst = out_inst; s_slot = out_slot;
    s_pop = in_pop; s_acc = out_valid & out_ready;
    @(posedge clk); #1;
    if (s_pop && pq.size() > 0) pq.delete(0);
    drive_head();
  endtask

  task automatic do_reset();
    rst_n = 0; flush = 0; out_ready = 0; pq.delete(); drive_head();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; pq.delete(); pq.push_back(mk(32'h1000, 2'b11, 32'h1, 32'h2)); drive_head();
    out_ready = 1; #2;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got %h exp 0", out_inst); end
    if (out_slot !== 1'b0) begin failures++; $display("FAIL reset_out_slot got %b exp 0", out_slot); end
    if (in_pop !== 1'b0) begin failures++; $display("FAIL reset_in_pop got %b exp 0", in_pop); end
    do_reset();
  endtask

  task automatic test_full_packet();
    do_reset(); out_ready = 1;
    pq.push_back(mk(32'hBFC00000, 2'b11, 32'h24010001, 32'h24020002)); drive_head();
    cyc();
    checks += 2;
    if (s_vld !== 1'b0) begin failures++; $display("FAIL full_c0_vld got %b exp 0", s_vld); end
    if (s_pop !== 1'b0) begin failures++; $display("FAIL full_c0_pop got %b exp 0", s_pop); end
    cyc();
    checks += 2;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'hBFC00000, 32'h24010001, 1'b0}) begin
      failures++; $display("FAIL full_slot0 got v=%b pc=%h inst=%h s=%b exp 1 bfc00000 24010001 0", s_vld, s_pc, s_inst, s_slot); end
    if (s_pop !== 1'b1) begin failures++; $display("FAIL full_c1_pop got %b exp 1", s_pop); end
    cyc();
    checks += 2;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'hBFC00004, 32'h24020002, 1'b1}) begin
      failures++; $display("FAIL full_slot1 got v=%b pc=%h inst=%h s=%b exp 1 bfc00004 24020002 1", s_vld, s_pc, s_inst, s_slot); end
    if (s_pop !== 1'b0) begin failures++; $display("FAIL full_c2_pop got %b exp 0", s_pop); end
  endtask

  task automatic test_single_slots();
    do_reset(); out_ready = 1;
    pq.push_back(mk(32'h100, 2'b10, 32'hAAAA0000, 32'hAAAA0001));
    pq.push_back(mk(32'h108, 2'b01, 32'hBBBB0000, 32'hBBBB0001)); drive_head();
    cyc();
    checks++;
    if (s_pop !== 1'b1) begin failures++; $display("FAIL single_pop0 got %b exp 1", s_pop); end
    cyc();
    checks += 2;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'h104, 32'hAAAA0001, 1'b1}) begin
      failures++; $display("FAIL single_first got v=%b pc=%h inst=%h s=%b exp 1 104 aaaa0001 1", s_vld, s_pc, s_inst, s_slot); end
    if (s_pop !== 1'b1) begin failures++; $display("FAIL single_pop1 got %b exp 1", s_pop); end
    cyc();
    checks++;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'h108, 32'hBBBB0000, 1'b0}) begin
      failures++; $display("FAIL single_second got v=%b pc=%h inst=%h s=%b exp 1 108 bbbb0000 0", s_vld, s_pc, s_inst, s_slot); end
  endtask

  task automatic test_empty_packet();
    logic [31:0] got[$];
    int pops = 0, bubbles = 0, first = -1, lastc = -1;
    logic vh[8];
    do_reset(); out_ready = 1;
    pq.push_back(mk(32'h300, 2'b11, 32'h30, 32'h31));
    pq.push_back(mk(32'h308, 2'b00, 32'h40, 32'h41));
    pq.push_back(mk(32'h310, 2'b11, 32'h50, 32'h51)); drive_head();
    for (int c = 0; c < 8; c++) begin
      cyc();
      vh[c] = s_vld; pops += s_pop;
      if (s_acc) begin got.push_back(s_pc); if (first < 0) first = c; lastc = c; end
    end
    for (int c = 0; c < 8; c++) if (first >= 0 && c > first && c < lastc && !vh[c]) bubbles++;
    checks += 3;
    if (pops !== 3) begin failures++; $display("FAIL empty_pops got %0d exp 3", pops); end
    if (bubbles !== 1) begin failures++; $display("FAIL empty_bubbles got %0d exp 1", bubbles); end
    if (got.size() !== 4) begin failures++; $display("FAIL empty_count got %0d exp 4", got.size()); end
    else begin
      checks++;
      if ({got[0], got[1], got[2], got[3]} !== {32'h300, 32'h304, 32'h310, 32'h314}) begin
        failures++; $display("FAIL empty_order got %h %h %h %h exp 300 304 310 314", got[0], got[1], got[2], got[3]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 0;
    pq.push_back(mk(32'h400, 2'b11, 32'h60, 32'h61)); drive_head();
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks += 2;
      if ({s_vld, s_pc, s_slot} !== {1'b1, 32'h400, 1'b0}) begin
        failures++; $display("FAIL bp_hold got v=%b pc=%h s=%b exp 1 400 0", s_vld, s_pc, s_slot); end
      if (s_pop !== 1'b0) begin failures++; $display("FAIL bp_pop got %b exp 0", s_pop); end
    end
    checks++;
    if (dut.ptr !== 1'b1) begin failures++; $display("FAIL bp_ptr got %b exp 1", dut.ptr); end
    out_ready = 1;
    cyc();
    checks += 2;
    if ({s_vld, s_pc, s_inst} !== {1'b1, 32'h400, 32'h60}) begin
      failures++; $display("FAIL bp_rel0 got v=%b pc=%h inst=%h exp 1 400 60", s_vld, s_pc, s_inst); end
    if (s_pop !== 1'b1) begin failures++; $display("FAIL bp_rel_pop got %b exp 1", s_pop); end
    cyc();
    checks++;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'h404, 32'h61, 1'b1}) begin
      failures++; $display("FAIL bp_rel1 got v=%b pc=%h inst=%h s=%b exp 1 404 61 1", s_vld, s_pc, s_inst, s_slot); end
  endtask

  task automatic test_flush();
    do_reset(); out_ready = 0;
    pq.push_back(mk(32'h500, 2'b11, 32'h70, 32'h71)); drive_head();
    cyc(); cyc();
    flush = 1;
    cyc();
    checks++;
    if (s_pop !== 1'b0) begin failures++; $display("FAIL flush_pop got %b exp 0", s_pop); end
    flush = 0; pq.delete();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_vld got %b exp 0", out_valid); end
    if (dut.ptr !== 1'b0) begin failures++; $display("FAIL flush_ptr got %b exp 0", dut.ptr); end
    pq.push_back(mk(32'h200, 2'b11, 32'h80, 32'h81)); drive_head(); out_ready = 1;
    cyc(); cyc();
    checks++;
    if ({s_vld, s_pc, s_inst, s_slot} !== {1'b1, 32'h200, 32'h80, 1'b0}) begin
      failures++; $display("FAIL flush_new got v=%b pc=%h inst=%h s=%b exp 1 200 80 0", s_vld, s_pc, s_inst, s_slot); end
  endtask

  task automatic test_random();
    ins_t exp_q[$];
    int npkt = 60, pops = 0, guard = 0;
    do_reset();
    for (int n = 0; n < npkt; n++) begin
      pkt_t p = mk({$urandom, 3'b000} & 32'hFFFF_FFF8, 2'($urandom), $urandom, $urandom);
      pq.push_back(p);
      for (int s = 0; s < 2; s++) if (p.m[s]) begin
        ins_t e; e.pc = p.pc + 32'(4 * s); e.inst = s ? p.i1 : p.i0; e.slot = 1'(s);
        exp_q.push_back(e);
      end
    end
    drive_head();
    while ((exp_q.size() > 0 || pq.size() > 0) && guard < 3000) begin
      out_ready = ($urandom % 4) != 0;
      cyc(); guard++; pops += s_pop;
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_extra got pc=%h exp none", s_pc); end
        else begin
          if ({s_pc, s_inst, s_slot} !== {exp_q[0].pc, exp_q[0].inst, exp_q[0].slot}) begin
            failures++; $display("FAIL rand_inst got pc=%h inst=%h s=%b exp pc=%h inst=%h s=%b",
              s_pc, s_inst, s_slot, exp_q[0].pc, exp_q[0].inst, exp_q[0].slot); end
          exp_q.delete(0);
        end
      end
    end
    checks += 2;
    if (guard >= 3000) begin failures++; $display("FAIL rand_timeout got %0d left exp 0", exp_q.size()); end
    if (pops !== npkt) begin failures++; $display("FAIL rand_pops got %0d exp %0d", pops, npkt); end
  endtask

`ifdef FETCH_UNPACK_PERF_EN
  task automatic test_perf();
    do_reset();
    checks += 2;
    if (perf_inst_cnt !== 0) begin failures++; $display("FAIL perf_rst_inst got %0d exp 0", perf_inst_cnt); end
    if (perf_bubble_cnt !== 0) begin failures++; $display("FAIL perf_rst_bub got %0d exp 0", perf_bubble_cnt); end
    out_ready = 1;
    for (int n = 0; n < 10; n++) pq.push_back(mk(32'h1000 + 32'(8 * n), 2'b11, $urandom, $urandom));
    drive_head();
    // 1 fill bubble, 20 accepts, then 3 idle ready cycles.
    for (int c = 0; c < 24; c++) cyc();
    checks += 2;
    if (perf_inst_cnt !== 32'd20) begin failures++; $display("FAIL perf_inst got %0d exp 20", perf_inst_cnt); end
    if (perf_bubble_cnt !== 32'd4) begin failures++; $display("FAIL perf_bubble got %0d exp 4", perf_bubble_cnt); end
    for (int n = 0; n < 3; n++) pq.push_back(mk(32'h2000 + 32'(8 * n), 2'b11, $urandom, $urandom));
    drive_head(); cyc(); cyc(); cyc();
    #2 rst_n = 0; #1;
    checks += 2;
    if (perf_inst_cnt !== 0) begin failures++; $display("FAIL perf_async_inst got %0d exp 0", perf_inst_cnt); end
    if (perf_bubble_cnt !== 0) begin failures++; $display("FAIL perf_async_bub got %0d exp 0", perf_bubble_cnt); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_full_packet();
    test_single_slots();
    test_empty_packet();
    test_backpressure();
    test_flush();
    test_random();
`ifdef FETCH_UNPACK_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
